mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 64, meaning the maximum number of cycles a memory operation may wait before it is aborted.
REQ-002 The block SHALL have the following ports, with clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- in_valid  in  1  an instruction is presented from the EX/MEM pipeline register.
- in_pc_data  in  32  PC of the presented instruction.
- in_rs2_data  in  32  store data.
- in_rd_address  in  5  destination register.
- in_alu_rd_result  in  32  ALU result; byte address for loads and stores.
- in_reg_write_data_src  in  1  1 = load (write-back data comes from memory); 0 = ALU result.
- in_reg_wren  in  1  the instruction writes the register file.
- in_ram_wren  in  1  the instruction is a store.
- stall  out  1  hold request to upstream; the EX/MEM pipeline register's wren is driven low while this is high.
- mem_req  out  1  data-RAM request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  RAM accepted the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- out_valid  out  1  MEM/WB outputs are valid this cycle.
- pc_data  out  32  PC to write-back.
- rd_address  out  5  destination register to write-back.
- reg_write_data  out  32  data to write to the register file.
- reg_wren  out  1  register-file write enable to write-back.
- misaligned_error  out  1  sticky error flag.
- timeout_error  out  1  sticky error flag.

Function
REQ-003 Definitions:
- A memory op is in_valid && (in_ram_wren || in_reg_write_data_src).
- A memory op is misaligned when in_alu_rd_result[1:0] != 0.
REQ-004 The block SHALL implement the FSM states IDLE, REQ and WAIT; inputs are sampled only in IDLE.
REQ-005 Non-memory op in IDLE:
- stall=0.
- Next edge: out_valid=1, pc_data/rd_address/reg_wren copied, reg_write_data=in_alu_rd_result.
- Latency is 1 cycle.
REQ-006 Misaligned memory op in IDLE:
- No RAM access, stall=0.
- Next edge: out_valid=1, reg_wren=0, misaligned_error set.
REQ-007 Aligned memory op in IDLE:
- stall=1 combinationally.
- Next edge: the op is latched into internal registers and the FSM goes to REQ.
REQ-008 Outputs in REQ:
- mem_req=1, mem_we=latched in_ram_wren, mem_addr=latched address, mem_wdata=latched rs2 data.
- mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_gnt.
REQ-009 Transitions from REQ:
- Store, mem_gnt=1: the store is complete, FSM goes to IDLE, and out_valid=1 with reg_wren=0 on that edge.
- Load, mem_gnt=1: FSM goes to WAIT, mem_req drops to 0.
REQ-010 In WAIT, mem_rvalid=1 SHALL return the FSM to IDLE with out_valid=1, reg_write_data=mem_rdata and reg_wren=latched reg_wren on that edge.
REQ-011 mem_rvalid SHALL be ignored outside WAIT; mem_rvalid in the same cycle as mem_gnt SHALL be ignored.
REQ-012 stall SHALL be 1 in REQ and WAIT, except in the completion cycle (store gnt, or load rvalid), where it is 0 so that upstream advances on the same edge that out_valid is registered.
REQ-013 out_valid SHALL be a single-cycle pulse per retired instruction; all other outputs SHALL hold their values when out_valid=0.
REQ-014 A timeout counter SHALL:
- clear on entry to REQ and increment each cycle in REQ/WAIT;
- saturate at MEM_TIMEOUT.
REQ-015 When the counter reaches MEM_TIMEOUT-1 without completion:
- the FSM goes to IDLE, mem_req drops, timeout_error is set;
- out_valid=1 with reg_wren=0;
- stall=0 in that cycle.
REQ-016 The error flags SHALL be sticky until reset.
REQ-017 Address arithmetic: mem_addr = {latched address[31:2], 2'b00}; no byte or halfword accesses.

Reset
REQ-018 When reset=1 at an edge, the following SHALL hold at that edge:
- FSM state = IDLE.
- stall, mem_req, mem_we = 0.
- mem_addr, mem_wdata = 0.
- out_valid, reg_wren = 0.
- pc_data, rd_address, reg_write_data = 0.
- Timeout counter = 0.
- misaligned_error, timeout_error = 0.
REQ-019 Reset during REQ or WAIT SHALL abandon the operation:
- No out_valid pulse is produced.
- A late mem_rvalid or mem_gnt after reset SHALL be ignored.

Verification
REQ-020 ALU op, pc=0x100, rd=5, alu=0x1234, reg_wren=1 -> next cycle out_valid=1, reg_write_data=0x1234, rd_address=5, stall never high.
REQ-021 Load at 0x40, mem_gnt after 2 cycles, mem_rvalid 3 cycles later with 0xDEADBEEF -> out_valid=1, reg_write_data=0xDEADBEEF; stall high for exactly 5 cycles, and the acceptance cycle is the first of those.
REQ-022 Store at 0x80, data 0xA5A5A5A5, mem_gnt on the first REQ cycle -> mem_we=1, mem_addr=0x80, mem_wdata=0xA5A5A5A5; out_valid=1 with reg_wren=0; stall high for 1 cycle.
REQ-023 Load at 0x42 -> mem_req never asserted, out_valid=1 with reg_wren=0, misaligned_error=1.
REQ-024 Load, mem_gnt held 0 for MEM_TIMEOUT cycles -> timeout_error=1, out_valid=1 with reg_wren=0, FSM back in IDLE; the next ALU op then retires normally.
REQ-025 Reset asserted in WAIT, then mem_rvalid pulses -> no out_valid pulse, all outputs 0, stall=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: retires ALU ops in one cycle and runs loads/stores over a
// req/gnt + rvalid RAM handshake, with alignment and timeout error reporting.
module mem_access_stage #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc_data,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rd_address,
  input  logic [31:0] in_alu_rd_result,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  input  logic        in_ram_wren,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] pc_data,
  output logic [4:0]  rd_address,
  output logic [31:0] reg_write_data,
  output logic        reg_wren,
  output logic        misaligned_error,
  output logic        timeout_error
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lat_we_q, lat_we_d;
  logic [31:0]   lat_addr_q, lat_addr_d;
  logic [31:0]   lat_wdata_q, lat_wdata_d;
  logic [31:0]   lat_pc_q, lat_pc_d;
  logic [4:0]    lat_rd_q, lat_rd_d;
  logic          lat_wren_q, lat_wren_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   pc_q, pc_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   rwd_q, rwd_d;
  logic          reg_wren_q, reg_wren_d;
  logic          mis_err_q, mis_err_d;
  logic          to_err_q, to_err_d;

  logic is_mem_op;
  logic is_misaligned;
  logic timeout_hit;

  assign is_mem_op     = in_valid && (in_ram_wren || in_reg_write_data_src);
  assign is_misaligned = (in_alu_rd_result[1:0] != 2'b00);
  assign timeout_hit   = (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_pc_d    = lat_pc_q;
    lat_rd_d    = lat_rd_q;
    lat_wren_d  = lat_wren_q;
    out_valid_d = 1'b0;
    pc_d        = pc_q;
    rd_d        = rd_q;
    rwd_d       = rwd_q;
    reg_wren_d  = reg_wren_q;
    mis_err_d   = mis_err_q;
    to_err_d    = to_err_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && (!is_mem_op || is_misaligned)) begin
          out_valid_d = 1'b1;
          pc_d        = in_pc_data;
          rd_d        = in_rd_address;
          rwd_d       = in_alu_rd_result;
          reg_wren_d  = is_mem_op ? 1'b0 : in_reg_wren;
          if (is_mem_op) mis_err_d = 1'b1;
        end else if (is_mem_op) begin
          stall       = 1'b1;
          state_d     = REQ;
          cnt_d       = '0;
          lat_we_d    = in_ram_wren;
          lat_addr_d  = in_alu_rd_result;
          lat_wdata_d = in_rs2_data;
          lat_pc_d    = in_pc_data;
          lat_rd_d    = in_rd_address;
          lat_wren_d  = in_reg_wren;
        end
      end
      REQ, WAIT: begin
        stall = 1'b1;
        cnt_d = (cnt_q == CW'(MEM_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        // Completion beats timeout; a load grant is not a completion.
        if ((state_q == REQ && mem_gnt && lat_we_q) || (state_q == WAIT && mem_rvalid)) begin
          stall       = 1'b0;
          state_d     = IDLE;
          out_valid_d = 1'b1;
          pc_d        = lat_pc_q;
          rd_d        = lat_rd_q;
          rwd_d       = lat_we_q ? lat_addr_q : mem_rdata;
          reg_wren_d  = lat_we_q ? 1'b0 : lat_wren_q;
        end else if (timeout_hit) begin
          stall       = 1'b0;
          state_d     = IDLE;
          out_valid_d = 1'b1;
          pc_d        = lat_pc_q;
          rd_d        = lat_rd_q;
          rwd_d       = lat_addr_q;
          reg_wren_d  = 1'b0;
          to_err_d    = 1'b1;
        end else if (state_q == REQ && mem_gnt) begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_pc_q    <= '0;
      lat_rd_q    <= '0;
      lat_wren_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      rwd_q       <= '0;
      reg_wren_q  <= 1'b0;
      mis_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_pc_q    <= lat_pc_d;
      lat_rd_q    <= lat_rd_d;
      lat_wren_q  <= lat_wren_d;
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      rwd_q       <= rwd_d;
      reg_wren_q  <= reg_wren_d;
      mis_err_q   <= mis_err_d;
      to_err_q    <= to_err_d;
    end
  end

  // Request fields come straight from the latch, so they cannot move before the grant.
  assign mem_req          = (state_q == REQ);
  assign mem_we           = (state_q == REQ) && lat_we_q;
  assign mem_addr         = {lat_addr_q[31:2], 2'b00};
  assign mem_wdata        = lat_wdata_q;
  assign out_valid        = out_valid_q;
  assign pc_data          = pc_q;
  assign rd_address       = rd_q;
  assign reg_write_data   = rwd_q;
  assign reg_wren         = reg_wren_q;
  assign misaligned_error = mis_err_q;
  assign timeout_error    = to_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage against a per-operation
// outcome model (retire cycle, written data, error flags).
module tb_mem_access_stage;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc_data, in_rs2_data, in_alu_rd_result;
  logic [4:0]  in_rd_address;
  logic        in_reg_write_data_src, in_reg_wren, in_ram_wren;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] pc_data, reg_write_data;
  logic [4:0]  rd_address;
  logic        reg_wren, misaligned_error, timeout_error;

  int total = 0;
  int bad   = 0;
  logic exp_mis = 1'b0;
  logic exp_to  = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc_data(in_pc_data),
    .in_rs2_data(in_rs2_data), .in_rd_address(in_rd_address),
    .in_alu_rd_result(in_alu_rd_result), .in_reg_write_data_src(in_reg_write_data_src),
    .in_reg_wren(in_reg_wren), .in_ram_wren(in_ram_wren), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .pc_data(pc_data), .rd_address(rd_address),
    .reg_write_data(reg_write_data), .reg_wren(reg_wren),
    .misaligned_error(misaligned_error), .timeout_error(timeout_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, stall, 0);
    check({tag, ".mem_req"}, mem_req, 0);
    check({tag, ".mem_we"}, mem_we, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".pc_data"}, pc_data, 0);
    check({tag, ".rd_address"}, rd_address, 0);
    check({tag, ".reg_write_data"}, reg_write_data, 0);
    check({tag, ".reg_wren"}, reg_wren, 0);
    check({tag, ".misaligned_error"}, misaligned_error, 0);
    check({tag, ".timeout_error"}, timeout_error, 0);
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store. g = REQ cycle carrying the grant,
  // v = WAIT cycle carrying read data (both 1-based).
  task automatic run_op(input string tag, input int kind, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic wren,
                        input int g, input int v, input logic [31:0] rdata);
    int          end_k, c, stalls, hs_bad;
    logic        is_mem, mis, exp_wren, chk_rwd, exp_req;
    logic [31:0] exp_rwd;
    is_mem   = (kind != 0);
    mis      = is_mem && (addr[1:0] != 2'b00);
    exp_rwd  = addr;
    chk_rwd  = 1'b0;
    c        = 0;
    if (!is_mem) begin
      end_k = 0; exp_wren = wren; chk_rwd = 1'b1;
    end else if (mis) begin
      end_k = 0; exp_wren = 1'b0; exp_mis = 1'b1;
    end else begin
      c = (kind == 2) ? g : g + v;
      if (c <= T) begin
        end_k    = c;
        exp_wren = (kind == 1) ? wren : 1'b0;
        if (kind == 1) begin exp_rwd = rdata; chk_rwd = 1'b1; end
      end else begin
        end_k = T; exp_wren = 1'b0; exp_to = 1'b1;
      end
    end

    stalls = 0;
    hs_bad = 0;
    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      in_valid              = (k == 0);
      in_pc_data            = pc;
      in_rd_address         = rd;
      in_alu_rd_result      = addr;
      in_rs2_data           = wdata;
      in_reg_wren           = wren;
      in_ram_wren           = (kind == 2);
      in_reg_write_data_src = (kind == 1);
      mem_rdata             = rdata;
      mem_gnt               = (k >= 1) && (k == g);
      // Stray read-valid before/with the grant must be ignored.
      mem_rvalid            = ((k >= 1) && (k <= g) && ($urandom_range(0, 1) == 1)) ||
                              ((kind == 1) && (k == g + v));
      #1;
      if (stall) stalls++;
      exp_req = is_mem && !mis && (k >= 1) && (k <= g);
      if (mem_req !== exp_req) hs_bad++;
      if (exp_req && ((mem_addr !== {addr[31:2], 2'b00}) || (mem_we !== (kind == 2)) ||
                      ((kind == 2) && (mem_wdata !== wdata)))) hs_bad++;
      @(posedge clk);
      #1;
      if ((k < end_k) && out_valid) hs_bad++;
    end

    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".reg_wren"}, reg_wren, exp_wren);
    check({tag, ".pc_data"}, pc_data, pc);
    check({tag, ".rd_address"}, rd_address, rd);
    if (chk_rwd) check({tag, ".reg_write_data"}, reg_write_data, exp_rwd);
    check({tag, ".misaligned_error"}, misaligned_error, exp_mis);
    check({tag, ".timeout_error"}, timeout_error, exp_to);
    check({tag, ".stall_cycles"}, stalls, end_k);
    check({tag, ".handshake"}, hs_bad, 0);

    @(negedge clk);
    in_valid   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".pulse_end"}, out_valid, 0);
    check({tag, ".pc_hold"}, pc_data, pc);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_pc_data = '0; in_rs2_data = '0; in_rd_address = '0;
    in_alu_rd_result = '0; in_reg_write_data_src = 1'b0; in_reg_wren = 1'b0;
    in_ram_wren = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    run_op("alu", 0, 32'h100, 5'd5, 32'h1234, 32'h0, 1'b1, 0, 0, 32'h0);
    run_op("load40", 1, 32'h104, 5'd6, 32'h40, 32'h0, 1'b1, 2, 3, 32'hDEADBEEF);
    run_op("store80", 2, 32'h108, 5'd0, 32'h80, 32'hA5A5A5A5, 1'b0, 1, 0, 32'h0);
    run_op("load42", 1, 32'h10C, 5'd7, 32'h42, 32'h0, 1'b1, 1, 1, 32'h0);
    run_op("timeout", 1, 32'h110, 5'd8, 32'h44, 32'h0, 1'b1, T + 5, 1, 32'h0);
    run_op("alu_after_to", 0, 32'h114, 5'd9, 32'h5678, 32'h0, 1'b1, 0, 0, 32'h0);
    run_op("store_late", 2, 32'h118, 5'd0, 32'h8C, 32'h11223344, 1'b1, T, 0, 32'h0);

    for (int i = 0; i < 30; i++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op("rand", kind, $urandom, 5'($urandom), a, $urandom, 1'($urandom),
             $urandom_range(1, T), $urandom_range(1, T - 2), $urandom);
    end

    // Reset while a load waits for data; the late rvalid must not retire anything.
    @(negedge clk);
    in_valid = 1'b1; in_alu_rd_result = 32'h200; in_reg_write_data_src = 1'b1;
    in_ram_wren = 1'b0; in_reg_wren = 1'b1; in_pc_data = 32'h300; in_rd_address = 5'd3;
    @(negedge clk);
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("rst_wait.stall_in_wait", stall, 1);
    check("rst_wait.mem_req_in_wait", mem_req, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_wait");
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wait.no_pulse", out_valid, 0);
    check("rst_wait.stall_idle", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
